// File: rtl/column_pool_writer.sv
// column_pool_writer: gathers one column of IMG_ROW lanes whose done pulses
// arrive in any order, optionally max-pools pairs of columns, requantizes
// each lane to signed 8 bits and emits one packed write per finished column.
module column_pool_writer #(
    parameter int IMG_ROW = 54,
    parameter int SHIFT   = 4,
    parameter int ADDR_W  = 12
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    frame_start,
    input  logic [ADDR_W-1:0]       base_addr,
    input  logic                    pool_en,
    input  logic [IMG_ROW-1:0]      in_done,
    input  logic [IMG_ROW*16-1:0]   in_value,
    output logic                    wr_en,
    output logic [ADDR_W-1:0]       wr_addr,
    output logic [IMG_ROW*8-1:0]    wr_data,
    output logic                    busy,
    output logic                    overrun
);

    localparam logic [0:0] PAIR_FIRST  = 1'b0;
    localparam logic [0:0] PAIR_SECOND = 1'b1;

    logic [IMG_ROW-1:0]        mask;
    logic [IMG_ROW-1:0][15:0]  cur;
    logic [IMG_ROW-1:0][15:0]  hold;
    logic [IMG_ROW-1:0][15:0]  col_val;
    logic [0:0]                phase;
    logic                      pool_q;
    logic [ADDR_W-1:0]         addr_cnt;
    logic                      col_done;
    logic [IMG_ROW*8-1:0]      quant_direct;
    logic [IMG_ROW*8-1:0]      quant_pooled;

    // Arithmetic shift down, then clamp into the signed byte range.
    function automatic logic [7:0] quantize(input logic [15:0] v);
        logic signed [15:0] s;
        s = $signed(v) >>> SHIFT;
        if (s > 16'sd127)
            return 8'h7F;
        else if (s < -16'sd128)
            return 8'h80;
        else
            return s[7:0];
    endfunction

    // A lane that first reports this cycle already counts toward the column,
    // so the completing cycle's values are folded in before the write.
    assign col_done = &(mask | in_done);
    assign busy     = (mask != '0) | phase[0];

    // Merge fresh lane values with the captured ones and precompute both
    // write payloads (plain column and pooled pair).
    always_comb begin
        col_val      = cur;
        quant_direct = '0;
        quant_pooled = '0;
        for (int i = 0; i < IMG_ROW; i++) begin
            if (in_done[i] && !mask[i])
                col_val[i] = in_value[i*16 +: 16];
        end
        for (int i = 0; i < IMG_ROW; i++) begin
            quant_direct[i*8 +: 8] = quantize(col_val[i]);
            quant_pooled[i*8 +: 8] = quantize(($signed(hold[i]) > $signed(col_val[i]))
                                              ? hold[i] : col_val[i]);
        end
    end

    // Lane capture, column mask and sticky duplicate-done detection.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            mask    <= '0;
            cur     <= '0;
            overrun <= 1'b0;
        end else if (frame_start) begin
            mask    <= '0;
            overrun <= 1'b0;
        end else begin
            cur <= col_val;
            if ((in_done & mask) != '0)
                overrun <= 1'b1;
            mask <= col_done ? '0 : (mask | in_done);
        end
    end

    // Pairing phase, address counter and the registered write port.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            phase    <= PAIR_FIRST;
            pool_q   <= 1'b0;
            hold     <= '0;
            addr_cnt <= '0;
            wr_en    <= 1'b0;
            wr_addr  <= '0;
            wr_data  <= '0;
        end else begin
            wr_en <= 1'b0;
            if (frame_start) begin
                phase    <= PAIR_FIRST;
                pool_q   <= pool_en;
                addr_cnt <= base_addr;
            end else if (col_done) begin
                if (pool_q && phase == PAIR_FIRST) begin
                    hold  <= col_val;
                    phase <= PAIR_SECOND;
                end else begin
                    wr_en    <= 1'b1;
                    wr_addr  <= addr_cnt;
                    addr_cnt <= addr_cnt + ADDR_W'(1);
                    wr_data  <= pool_q ? quant_pooled : quant_direct;
                    phase    <= PAIR_FIRST;
                end
            end
        end
    end

endmodule

// File: tb/tb_column_pool_writer.sv
// tb_column_pool_writer: directed scenarios plus randomized traffic, all
// checked against a column-level reference model held in the bench.
module tb_column_pool_writer;

    localparam int IMG_ROW = 54;
    localparam int SHIFT   = 4;
    localparam int ADDR_W  = 12;
    localparam int DW      = IMG_ROW * 8;

    logic                  clk = 1'b0;
    logic                  reset = 1'b1;
    logic                  frame_start = 1'b0;
    logic [ADDR_W-1:0]     base_addr = '0;
    logic                  pool_en = 1'b0;
    logic [IMG_ROW-1:0]    in_done = '0;
    logic [IMG_ROW*16-1:0] in_value = '0;
    logic                  wr_en;
    logic [ADDR_W-1:0]     wr_addr;
    logic [DW-1:0]         wr_data;
    logic                  busy;
    logic                  overrun;

    column_pool_writer #(.IMG_ROW(IMG_ROW), .SHIFT(SHIFT), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .reset(reset), .frame_start(frame_start), .base_addr(base_addr),
        .pool_en(pool_en), .in_done(in_done), .in_value(in_value),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .busy(busy), .overrun(overrun)
    );

    // Free-running 10-unit clock.
    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model: which lanes have reported, their values, and the
    // waiting first column of a pooling pair.
    bit             m_got   [IMG_ROW];
    logic [15:0]    m_val   [IMG_ROW];
    logic [15:0]    m_first [IMG_ROW];
    bit             m_have_first, m_pool, m_ovr;
    int             m_addr;
    bit             e_wr_en;
    logic [ADDR_W-1:0] e_addr;
    logic [DW-1:0]  e_data;

    task automatic check_output(input string tag, input logic [DW-1:0] observed,
                                input logic [DW-1:0] expected);
        compared++;
        if (observed !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, observed, expected);
        end
    endtask

    function automatic logic [7:0] ref_quant(input int v);
        int q;
        q = v >>> SHIFT;
        if (q > 127) q = 127;
        if (q < -128) q = -128;
        return 8'(q);
    endfunction

    function automatic logic [IMG_ROW*16-1:0] fill16(input logic [15:0] v);
        logic [IMG_ROW*16-1:0] r;
        for (int i = 0; i < IMG_ROW; i++) r[i*16 +: 16] = v;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < IMG_ROW; i++) begin
            m_got[i] = 1'b0; m_val[i] = '0; m_first[i] = '0;
        end
        m_have_first = 0; m_pool = 0; m_ovr = 0; m_addr = 0;
        e_wr_en = 0; e_addr = '0; e_data = '0;
    endtask

    task automatic model_edge(input logic fs, input logic [ADDR_W-1:0] base, input logic pen,
                              input logic [IMG_ROW-1:0] done, input logic [IMG_ROW*16-1:0] value);
        bit all;
        int a, b;
        e_wr_en = 0;
        if (fs) begin
            for (int i = 0; i < IMG_ROW; i++) m_got[i] = 0;
            m_have_first = 0; m_ovr = 0; m_addr = int'(base); m_pool = pen;
        end else begin
            all = 1;
            for (int i = 0; i < IMG_ROW; i++) begin
                if (done[i]) begin
                    if (m_got[i]) m_ovr = 1;
                    else begin m_got[i] = 1; m_val[i] = value[i*16 +: 16]; end
                end
                if (!m_got[i]) all = 0;
            end
            if (all) begin
                for (int i = 0; i < IMG_ROW; i++) m_got[i] = 0;
                if (m_pool && !m_have_first) begin
                    for (int i = 0; i < IMG_ROW; i++) m_first[i] = m_val[i];
                    m_have_first = 1;
                end else begin
                    for (int i = 0; i < IMG_ROW; i++) begin
                        a = int'($signed(m_val[i]));
                        if (m_pool) begin
                            b = int'($signed(m_first[i]));
                            if (b > a) a = b;
                        end
                        e_data[i*8 +: 8] = ref_quant(a);
                    end
                    e_wr_en = 1;
                    e_addr = ADDR_W'(m_addr);
                    m_addr = (m_addr + 1) % (1 << ADDR_W);
                    m_have_first = 0;
                end
            end
        end
    endtask

    task automatic check_all();
        bit m_busy;
        m_busy = m_have_first;
        for (int i = 0; i < IMG_ROW; i++) if (m_got[i]) m_busy = 1;
        check_output("wr_en",   DW'(wr_en),   DW'(e_wr_en));
        check_output("wr_addr", DW'(wr_addr), DW'(e_addr));
        check_output("wr_data", wr_data,      e_data);
        check_output("busy",    DW'(busy),    DW'(m_busy));
        check_output("overrun", DW'(overrun), DW'(m_ovr));
    endtask

    // One clock: drive on the falling edge, advance the model at the rising
    // edge, compare everything just after it.
    task automatic apply_stimulus(input logic fs, input logic [ADDR_W-1:0] base, input logic pen,
                                  input logic [IMG_ROW-1:0] done, input logic [IMG_ROW*16-1:0] value);
        @(negedge clk);
        frame_start = fs; base_addr = base; pool_en = pen; in_done = done; in_value = value;
        @(posedge clk);
        model_edge(fs, base, pen, done, value);
        #1;
        check_all();
    endtask

    task automatic do_reset();
        @(negedge clk);
        frame_start = 0; in_done = '0;
        #1 reset = 1'b1;
        model_reset();
        #1 check_all();
        @(negedge clk);
        reset = 1'b0;
        #1 check_all();
    endtask

    logic [IMG_ROW-1:0]    all_on, lo_half, hi_half, not5, rnd_done;
    logic [IMG_ROW*16-1:0] v;

    initial begin
        all_on  = '1;
        lo_half = '0;
        for (int i = 0; i < IMG_ROW / 2; i++) lo_half[i] = 1'b1;
        hi_half = ~lo_half;
        not5    = all_on;
        not5[5] = 1'b0;

        model_reset();
        #2 check_all();
        @(negedge clk);
        reset = 1'b0;

        // First column straight through.
        apply_stimulus(1, 12'h010, 0, '0, '0);
        apply_stimulus(0, '0, 0, all_on, fill16(16'h0100));
        check_output("t1_wr_en", DW'(wr_en), DW'(1'b1));
        check_output("t1_addr",  DW'(wr_addr), DW'(12'h010));
        check_output("t1_data",  wr_data, {IMG_ROW{8'h10}});
        apply_stimulus(0, '0, 0, '0, '0);
        check_output("t1_single", DW'(wr_en), DW'(1'b0));

        // Staggered halves.
        apply_stimulus(0, '0, 0, lo_half, fill16(16'h0230));
        check_output("t2_busy_a", DW'(busy), DW'(1'b1));
        apply_stimulus(0, '0, 0, '0, '0);
        check_output("t2_busy_b", DW'(busy), DW'(1'b1));
        apply_stimulus(0, '0, 0, hi_half, fill16(16'hFE00));
        check_output("t2_wr", DW'(wr_en), DW'(1'b1));
        apply_stimulus(0, '0, 0, '0, '0);
        check_output("t2_idle", DW'(busy), DW'(1'b0));

        // Vertical pooling pair.
        apply_stimulus(1, 12'h020, 1, '0, '0);
        v = fill16(16'h0000); v[15:0] = 16'h0050; v[31:16] = 16'hFF00;
        apply_stimulus(0, '0, 0, all_on, v);
        check_output("t3_no_wr", DW'(wr_en), DW'(1'b0));
        v = fill16(16'h0000); v[15:0] = 16'h0030; v[31:16] = 16'hFFF0;
        apply_stimulus(0, '0, 0, all_on, v);
        check_output("t3_wr", DW'(wr_en), DW'(1'b1));
        check_output("t3_lanes", DW'(wr_data[15:0]), DW'(16'hFF05));

        // Saturation.
        apply_stimulus(1, 12'h030, 0, '0, '0);
        v = fill16(16'h0000);
        v[15:0] = 16'h7FFF; v[31:16] = 16'h8000; v[47:32] = 16'h07F0; v[63:48] = 16'hF800;
        apply_stimulus(0, '0, 0, all_on, v);
        check_output("t4_sat", DW'(wr_data[31:0]), DW'(32'h807F807F));

        // Duplicate done on lane 5.
        v = fill16(16'h0200);
        apply_stimulus(0, '0, 0, 54'd1 << 5, v);
        v = fill16(16'h1234);
        apply_stimulus(0, '0, 0, 54'd1 << 5, v);
        check_output("t5_ovr", DW'(overrun), DW'(1'b1));
        apply_stimulus(0, '0, 0, not5, fill16(16'h0000));
        check_output("t5_lane5", DW'(wr_data[47:40]), DW'(8'h20));
        apply_stimulus(1, 12'h040, 0, '0, '0);
        check_output("t5_clr", DW'(overrun), DW'(1'b0));

        // Address wrap, then reset with a half column pending.
        apply_stimulus(1, 12'hFFF, 0, '0, '0);
        apply_stimulus(0, '0, 0, all_on, fill16(16'h0011));
        check_output("t6_addr_a", DW'(wr_addr), DW'(12'hFFF));
        apply_stimulus(0, '0, 0, all_on, fill16(16'h0022));
        check_output("t6_addr_b", DW'(wr_addr), DW'(12'h000));
        apply_stimulus(0, '0, 0, lo_half, fill16(16'h0033));
        do_reset();
        check_output("t6_rst_data", wr_data, '0);
        for (int k = 0; k < 3; k++) apply_stimulus(0, '0, 0, '0, '0);
        check_output("t6_no_wr", DW'(wr_en), DW'(1'b0));

        // Randomized traffic.
        for (int n = 0; n < 400; n++) begin
            for (int i = 0; i < IMG_ROW; i++) v[i*16 +: 16] = 16'($urandom);
            if ($urandom_range(0, 7) == 0) rnd_done = all_on;
            else for (int i = 0; i < IMG_ROW; i++) rnd_done[i] = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 199) == 0)
                do_reset();
            else
                apply_stimulus($urandom_range(0, 39) == 0, ADDR_W'($urandom),
                               1'($urandom), rnd_done, v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/column_pool_writer.md
# column_pool_writer

Downstream consumer of the convolution/horizontal-max-pool/leaky-ReLU lane array. It collects one output column of `IMG_ROW` 16-bit lanes, whose per-lane `done` pulses may arrive in any cycles. It optionally applies a 2:1 vertical (column-to-column) signed max pool, requantizes each lane to signed 8-bit, and issues one packed write per finished column into the feature-map buffer for the next layer.

## Interface
Parameters:
- `IMG_ROW`, 54: number of lanes; must be even.
- `SHIFT`, 4: arithmetic right shift applied during requantization (0..15).
- `ADDR_W`, 12: write-address width.

Ports:
- `clk` input 1: single clock; all logic on its rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `frame_start` input 1: one-cycle pulse; starts a new frame.
- `base_addr` input `ADDR_W`: first write address; sampled on `frame_start`.
- `pool_en` input 1: 1 = vertical 2:1 max pool; 0 = write every column; sampled on `frame_start`.
- `in_done` input `IMG_ROW`: per-lane valid pulse from the activation stage.
- `in_value` input `IMG_ROW*16`: lane `i` is bits `[(i+1)*16-1 : i*16]`, signed.
- `wr_en` output 1: one-cycle write strobe.
- `wr_addr` output `ADDR_W`: write address, valid with `wr_en`.
- `wr_data` output `IMG_ROW*8`: lane `i` is bits `[(i+1)*8-1 : i*8]`, signed.
- `busy` output 1: high while a column or pooling pair is partially collected.
- `overrun` output 1: sticky error flag.

## Operation
- Per-lane capture: when `in_done[i]=1` and `mask[i]=0`, latch lane `i` into `cur[i]` and set `mask[i]`.
- Duplicate done: if `in_done[i]=1` while `mask[i]=1`, the new value is discarded and `overrun` is set. `overrun` stays set until the next `frame_start` or `reset`.
- Column complete: occurs in the cycle where `(mask | in_done)` is all ones. That cycle's lane values are included. Next cycle `mask` is 0.
- `pool_en=0` path: on column complete, quantize `cur` and write.
- `pool_en=1` path, controlled by `phase`:
  - `phase=0`: on column complete, copy `cur` to `hold`, set `phase=1`, no write.
  - `phase=1`: on column complete, compute per-lane signed `max(hold[i], cur[i])`, quantize, write, and clear `phase`.
- Quantize: `q = value >>> SHIFT` (signed 16-bit arithmetic shift), then saturate to [-128, 127].
- Address: the first write uses `base_addr`. `wr_addr` increments by 1 after each write and wraps modulo 2^ADDR_W.
- `frame_start` actions: clears `mask`, `phase` and `overrun`; loads the address counter from `base_addr`; latches `pool_en`.
- `frame_start` priority: it wins over `in_done` in the same cycle, and `in_done` in that cycle is ignored. A pending write scheduled by the previous cycle's completion still issues, using the old address.
- `busy` = `(mask != 0) | phase`.
- FSM is two states (`phase`): PAIR_FIRST and PAIR_SECOND. It is only used when `pool_en=1` and stays in PAIR_FIRST otherwise.

## Timing
- Reset values: `wr_en=0`, `wr_addr=0`, `wr_data=0`, `busy=0`, `overrun=0`, `mask=0`, `phase=0`, latched `pool_en=0`.
- Latency: column completes at edge N, so `wr_en=1` in cycle N+1 with registered `wr_addr`/`wr_data`. `wr_en` lasts exactly one cycle.
- Throughput: one column per cycle is possible. If every lane asserts `in_done` each cycle, a write issues every cycle (`pool_en=0`) or every second cycle (`pool_en=1`).
- Back-to-back: a completion in cycle N and new dones in N+1 start the next column without loss.
- Reset mid-column discards all partial data. No write is produced for an incomplete column or an unpaired first column.
- `wr_data` holds its last value when `wr_en=0`.

## Test plan
- Reset then `frame_start`, `base_addr=0x010`, `pool_en=0`, all lanes done in one cycle with lane value 0x0100 -> next cycle `wr_en=1`, `wr_addr=0x010`, every `wr_data` byte 0x10.
- Staggered dones with `pool_en=0`: lanes 0..26 in cycle 1, lanes 27..53 in cycle 3, `busy=1` in cycles 2-3 -> single write in cycle 4 only, then `busy=0`.
- Pooling with `pool_en=1`: column A lane0=0x0050, lane1=0xFF00; column B lane0=0x0030, lane1=0xFFF0 -> one write, lane0=0x05, lane1=0xFF (-1). No write after column A.
- Saturation with `SHIFT=4`: lane values 0x7FFF and 0x8000 -> bytes 0x7F and 0x80. Values 0x07F0 and 0xF800 -> bytes 0x7F and 0x80.
- Overrun: lane 5 done twice before column completion, second value 0x1234 -> `overrun=1`, written lane 5 equals the first value. Next `frame_start` clears `overrun`.
- Wrap and reset: `base_addr=0xFFF`, two columns written -> addresses 0xFFF then 0x000. Assert `reset` with half of a column collected -> all outputs 0 and no subsequent write.
